romulus_round_seq: RTL and testbench

- Multi-cycle sequencer that runs ROUNDS rounds of the SKINNY-128-384+ round function over a 128-bit state held in four 32-bit row registers.
- Uses one shared romulus_ise instance for SubCells+AddConstant+AddRoundTweakey+ShiftRows, one row per cycle.
- MixColumns, the round-constant LFSR and the round counter are native logic in this block.
- Sits between the Romulus mode controller (which supplies the state and per-round tweakey via handshake) and the ISE datapath.

---
 rtl/romulus_pkg.sv | 33 +++
 rtl/romulus_ise.sv | 69 ++++++
 rtl/romulus_round_seq.sv | 135 +++++++++++++
 tb/tb_romulus_round_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/romulus_pkg.sv
// Shared definitions for the Romulus round sequencer: FSM encoding, ISE op
// selects, row-index constants and the SKINNY round-constant LFSR.
package romulus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_TK = 3'd1,
        ST_ROW     = 3'd2,
        ST_MIX     = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    // ISE op selects as wired by the sequencer: only the round step is used.
    localparam logic OP_RSTEP_ON = 1'b1;
    localparam logic OP_SBOX_ON  = 1'b0;
    localparam logic OP_SROW_ON  = 1'b0;

    // Row indices: rows 0/1 take tweakey material, row 2 a fixed constant.
    localparam logic [1:0] ROW_TK_LO = 2'd0;
    localparam logic [1:0] ROW_TK_HI = 2'd1;
    localparam logic [1:0] ROW_CONST = 2'd2;
    localparam logic [1:0] ROW_LAST  = 2'd3;

    localparam logic [31:0] ROW_CONST_XOR = 32'h0000_0002;

    localparam int RND_W = 6;

    // 6-bit round-constant LFSR: shift left, feed back x5 ^ x4 ^ 1.
    function automatic logic [5:0] rc_lfsr(input logic [5:0] x);
        return {x[4:0], x[5] ^ x[4] ^ 1'b1};
    endfunction

endpackage

// File: rtl/romulus_ise.sv
// Combinational SKINNY row datapath: bytewise S-box, round-key/constant
// addition and row rotation, selected by one-hot op inputs.
module romulus_ise
    import romulus_pkg::*;
(
    input  logic        op_rstep,
    input  logic        op_sbox,
    input  logic        op_srow,
    input  logic [1:0]  imm,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] rd
);

    // Four NOR/XOR mixing layers with bit permutations in between, then a final swap.
    function automatic logic [7:0] sbox8(input logic [7:0] a);
        logic [7:0] x;
        x = a;
        for (int r = 0; r < 3; r++) begin
            x[4] = x[4] ^ ~(x[7] | x[6]);
            x[0] = x[0] ^ ~(x[3] | x[2]);
            x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
        end
        x[4] = x[4] ^ ~(x[7] | x[6]);
        x[0] = x[0] ^ ~(x[3] | x[2]);
        return {x[7:3], x[1], x[2], x[0]};
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] n);
        logic [31:0] r;
        case (n)
            2'd0:    r = w;
            2'd1:    r = {w[23:0], w[31:24]};
            2'd2:    r = {w[15:0], w[31:16]};
            default: r = {w[7:0],  w[31:8]};
        endcase
        return r;
    endfunction

    logic [31:0] sub_word;
    logic [31:0] key_word;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            sub_word[8*b +: 8] = sbox8(rs1[8*b +: 8]);
        end
    end

    always_comb begin
        key_word = sub_word;
        case (imm)
            ROW_CONST: key_word = sub_word ^ ROW_CONST_XOR;
            ROW_LAST:  key_word = sub_word;
            default:   key_word = sub_word ^ rs2;
        endcase
    end

    always_comb begin
        rd = '0;
        if (op_rstep) begin
            rd = rotl_bytes(key_word, imm);
        end else if (op_sbox) begin
            rd = sub_word;
        end else if (op_srow) begin
            rd = rotl_bytes(rs1, imm);
        end
    end

endmodule

// File: rtl/romulus_round_seq.sv
// Multi-cycle SKINNY-128-384+ round sequencer: one ISE row step per cycle,
// native MixColumns, round-constant LFSR and round counter.
module romulus_round_seq
    import romulus_pkg::*;
#(
    parameter int ROUNDS = 40
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         start,
    input  logic [127:0] state_in,
    input  logic         rtk_valid,
    input  logic [63:0]  rtk,
    output logic         rtk_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy,
    output logic [5:0]   rnd_idx
);

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; ready/valid are pure functions of the FSM state.
    seq_state_e         state_q, state_d;
    logic [3:0][31:0]   rows_q;
    logic [63:0]        rtk_q;
    logic [5:0]         rc_q;
    logic [RND_W-1:0]   rnd_q;
    logic [1:0]         row_cnt_q;

    logic [31:0]        ise_rs1, ise_rs2, ise_rd;
    logic [31:0]        t1, t2, t3;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)                  state_d = ST_WAIT_TK;
            ST_WAIT_TK: if (rtk_valid)              state_d = ST_ROW;
            ST_ROW:     if (row_cnt_q == ROW_LAST)  state_d = ST_MIX;
            ST_MIX:     state_d = (rnd_q == LAST_RND) ? ST_DONE : ST_WAIT_TK;
            ST_DONE:    if (out_ready)              state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rtk_ready = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE:    busy      = 1'b0;
            ST_WAIT_TK: rtk_ready = 1'b1;
            ST_DONE:    out_valid = 1'b1;
            default:    ;
        endcase
    end

    // Only rows 0 and 1 carry tweakey material; the round constant is folded in here.
    always_comb begin
        ise_rs2 = '0;
        case (row_cnt_q)
            ROW_TK_LO: ise_rs2 = {rtk_q[31:4],  rtk_q[3:0]   ^ rc_q[3:0]};
            ROW_TK_HI: ise_rs2 = {rtk_q[63:34], rtk_q[33:32] ^ rc_q[5:4]};
            default:   ise_rs2 = '0;
        endcase
    end

    assign ise_rs1 = rows_q[row_cnt_q];

    romulus_ise u_ise (
        .op_rstep (OP_RSTEP_ON),
        .op_sbox  (OP_SBOX_ON),
        .op_srow  (OP_SROW_ON),
        .imm      (row_cnt_q),
        .rs1      (ise_rs1),
        .rs2      (ise_rs2),
        .rd       (ise_rd)
    );

    assign t1 = rows_q[1] ^ rows_q[2];
    assign t2 = rows_q[2] ^ rows_q[0];
    assign t3 = t2 ^ rows_q[3];

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rows_q    <= '0;
            rtk_q     <= '0;
            rc_q      <= '0;
            rnd_q     <= '0;
            row_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rows_q <= state_in;
                        rc_q   <= '0;
                        rnd_q  <= '0;
                    end
                end
                ST_WAIT_TK: begin
                    if (rtk_valid) begin
                        rtk_q     <= rtk;
                        rc_q      <= rc_lfsr(rc_q);
                        row_cnt_q <= '0;
                    end
                end
                ST_ROW: begin
                    rows_q[row_cnt_q] <= ise_rd;
                    row_cnt_q         <= row_cnt_q + 2'd1;
                end
                ST_MIX: begin
                    rows_q <= {t2, t1, rows_q[0], t3};
                    if (rnd_q != LAST_RND) begin
                        rnd_q <= rnd_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_out = rows_q;
    assign rnd_idx   = rnd_q;

endmodule

// File: tb/tb_romulus_round_seq.sv
// Directed bench for romulus_round_seq: three instances (1, 6 and 40 rounds)
// checked against hand-computed vectors and a reference round model.
module tb_romulus_round_seq;

    logic                g_clk;
    logic                g_resetn;
    logic [2:0]          start_v;
    logic [2:0][127:0]   state_in_v;
    logic [2:0]          rtk_valid_v;
    logic [2:0][63:0]    rtk_v;
    logic [2:0]          rtk_ready_v;
    logic [2:0]          out_valid_v;
    logic [2:0]          out_ready_v;
    logic [2:0][127:0]   state_out_v;
    logic [2:0]          busy_v;
    logic [2:0][5:0]     rnd_idx_v;

    int n_checks;
    int n_fail;
    logic [63:0] tk_tab[64];

    romulus_round_seq #(.ROUNDS(1)) dut_r1 (
        .g_clk(g_clk), .g_resetn(g_resetn), .start(start_v[0]), .state_in(state_in_v[0]),
        .rtk_valid(rtk_valid_v[0]), .rtk(rtk_v[0]), .rtk_ready(rtk_ready_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .state_out(state_out_v[0]),
        .busy(busy_v[0]), .rnd_idx(rnd_idx_v[0])
    );

    romulus_round_seq #(.ROUNDS(6)) dut_r6 (
        .g_clk(g_clk), .g_resetn(g_resetn), .start(start_v[1]), .state_in(state_in_v[1]),
        .rtk_valid(rtk_valid_v[1]), .rtk(rtk_v[1]), .rtk_ready(rtk_ready_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .state_out(state_out_v[1]),
        .busy(busy_v[1]), .rnd_idx(rnd_idx_v[1])
    );

    romulus_round_seq #(.ROUNDS(40)) dut_r40 (
        .g_clk(g_clk), .g_resetn(g_resetn), .start(start_v[2]), .state_in(state_in_v[2]),
        .rtk_valid(rtk_valid_v[2]), .rtk(rtk_v[2]), .rtk_ready(rtk_ready_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .state_out(state_out_v[2]),
        .busy(busy_v[2]), .rnd_idx(rnd_idx_v[2])
    );

    // Clock and reset
    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: word-parallel S-box, round-key add, ShiftRows, MixColumns
    function automatic logic [31:0] sb_mix(input logic [31:0] x);
        return ((~(((x >> 1) | x) >> 2)) & 32'h1111_1111) ^ x;
    endfunction

    function automatic logic [31:0] sb_perm(input logic [31:0] x);
        return ((x & 32'h0101_0101) << 2) | ((x & 32'h0606_0606) << 5) |
               ((x & 32'h2020_2020) >> 5) | ((x & 32'hC8C8_C8C8) >> 2) |
               ((x & 32'h1010_1010) >> 1);
    endfunction

    function automatic logic [31:0] sbox_word(input logic [31:0] x);
        logic [31:0] y;
        y = sb_mix(x);
        y = sb_mix(sb_perm(y));
        y = sb_mix(sb_perm(y));
        y = sb_mix(sb_perm(y));
        return (y & 32'hF9F9_F9F9) | ((y >> 1) & 32'h0202_0202) | ((y << 1) & 32'h0404_0404);
    endfunction

    function automatic logic [127:0] model_run(input logic [127:0] st, input int nr);
        logic [31:0] r[4];
        logic [31:0] w, a, b, c;
        logic [5:0]  rc;
        for (int i = 0; i < 4; i++) r[i] = st[32*i +: 32];
        rc = 6'd0;
        for (int n = 0; n < nr; n++) begin
            rc = {rc[4:0], ~(rc[5] ^ rc[4])};
            for (int i = 0; i < 4; i++) begin
                w = sbox_word(r[i]);
                if (i == 0) w = w ^ tk_tab[n][31:0] ^ {28'd0, rc[3:0]};
                if (i == 1) w = w ^ tk_tab[n][63:32] ^ {30'd0, rc[5:4]};
                if (i == 2) w = w ^ 32'h2;
                r[i] = (w << (8 * i)) | (w >> (32 - 8 * i));
            end
            a = r[1] ^ r[2];
            b = r[2] ^ r[0];
            c = b ^ r[3];
            r[3] = b;
            r[2] = a;
            r[1] = r[0];
            r[0] = c;
        end
        return {r[3], r[2], r[1], r[0]};
    endfunction

    // Driver: start a job on instance k and serve tweakeys until DONE (or abort).
    task automatic run_job(input int k, input logic [127:0] st, input int nr,
                           input int stall_rnd, input int stall_n, input int abort_rnd,
                           output int cycles);
        int rnd;
        int stalled;
        logic [127:0] hold;
        bit aborted;
        rnd = 0; stalled = 0; hold = '0; aborted = 1'b0;
        out_ready_v[k] = 1'b0;
        rtk_valid_v[k] = 1'b0;
        state_in_v[k] = st;
        start_v[k] = 1'b1;
        @(posedge g_clk); #1;
        start_v[k] = 1'b0;
        state_in_v[k] = {$urandom, $urandom, $urandom, $urandom};
        cycles = 1;
        while (!aborted && out_valid_v[k] !== 1'b1 && cycles < 4000) begin
            if (rtk_ready_v[k] === 1'b1 && rnd == stall_rnd && stalled < stall_n) begin
                if (stalled > 0) begin
                    n_checks++;
                    if (state_out_v[k] !== hold || busy_v[k] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL stall_hold: state_out=%h busy=%b required state_out=%h busy=1",
                                 state_out_v[k], busy_v[k], hold);
                    end
                end
                hold = state_out_v[k];
                stalled++;
                rtk_valid_v[k] = 1'b0;
                rtk_v[k] = {$urandom, $urandom};
            end else if (rtk_ready_v[k] === 1'b1) begin
                n_checks++;
                if (rnd_idx_v[k] !== 6'(rnd)) begin
                    n_fail++;
                    $display("FAIL rnd_idx_at_accept: got %0d required %0d", rnd_idx_v[k], rnd);
                end
                rtk_valid_v[k] = 1'b1;
                rtk_v[k] = tk_tab[rnd];
                rnd++;
            end else begin
                rtk_valid_v[k] = 1'($urandom_range(0, 1));
                rtk_v[k] = {$urandom, $urandom};
            end
            @(posedge g_clk); #1;
            cycles++;
            if (abort_rnd >= 0 && rnd == abort_rnd + 1) begin
                @(posedge g_clk); #2;
                g_resetn = 1'b0;
                #1;
                n_checks++;
                if (state_out_v[k] !== '0 || out_valid_v[k] !== 1'b0 || rtk_ready_v[k] !== 1'b0 ||
                    busy_v[k] !== 1'b0 || rnd_idx_v[k] !== 6'd0) begin
                    n_fail++;
                    $display("FAIL async_reset: state_out=%h ov=%b rr=%b busy=%b rnd=%0d required all zero",
                             state_out_v[k], out_valid_v[k], rtk_ready_v[k], busy_v[k], rnd_idx_v[k]);
                end
                aborted = 1'b1;
            end
        end
        rtk_valid_v[k] = 1'b0;
        if (!aborted) begin
            n_checks++;
            if (out_valid_v[k] !== 1'b1 || rnd != nr) begin
                n_fail++;
                $display("FAIL job_complete: out_valid=%b accepts=%0d required out_valid=1 accepts=%0d",
                         out_valid_v[k], rnd, nr);
            end
        end
    endtask

    task automatic finish_job(input int k);
        out_ready_v[k] = 1'b1;
        @(posedge g_clk); #1;
        out_ready_v[k] = 1'b0;
        n_checks++;
        if (out_valid_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL release: out_valid=%b busy=%b required 0 0", out_valid_v[k], busy_v[k]);
        end
    endtask

    task automatic check_result(input string name, input int k, input int cyc, input int exp_cyc,
                                input logic [127:0] exp_state);
        n_checks++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, cyc, exp_cyc);
        end
        n_checks++;
        if (state_out_v[k] !== exp_state) begin
            n_fail++;
            $display("FAIL %s_state: got %h required %h", name, state_out_v[k], exp_state);
        end
    endtask

    task automatic test_reset();
        g_resetn = 1'b0;
        start_v = '0; state_in_v = '0; rtk_valid_v = '0; rtk_v = '0; out_ready_v = '0;
        repeat (3) @(posedge g_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (state_out_v[k] !== '0 || out_valid_v[k] !== 1'b0 || rtk_ready_v[k] !== 1'b0 ||
                busy_v[k] !== 1'b0 || rnd_idx_v[k] !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: state_out=%h ov=%b rr=%b busy=%b rnd=%0d required all zero",
                         k, state_out_v[k], out_valid_v[k], rtk_ready_v[k], busy_v[k], rnd_idx_v[k]);
            end
        end
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
    endtask

    task automatic test_single_round();
        int cyc;
        tk_tab[0] = 64'd0;
        run_job(0, 128'd0, 1, -1, 0, -1, cyc);
        check_result("single_round", 0, cyc, 7,
                     128'h00020001_00020000_65656564_65676564);
        n_checks++;
        if (busy_v[0] !== 1'b1 || rtk_ready_v[0] !== 1'b0 || rnd_idx_v[0] !== 6'd0) begin
            n_fail++;
            $display("FAIL single_round_flags: busy=%b rr=%b rnd=%0d required 1 0 0",
                     busy_v[0], rtk_ready_v[0], rnd_idx_v[0]);
        end
        finish_job(0);
    endtask

    task automatic test_rc_sequence();
        int cyc;
        logic [127:0] st;
        for (int i = 0; i < 6; i++) tk_tab[i] = {$urandom, $urandom};
        st = {$urandom, $urandom, $urandom, $urandom};
        run_job(1, st, 6, -1, 0, -1, cyc);
        check_result("six_rounds", 1, cyc, 37, model_run(st, 6));
        finish_job(1);
    endtask

    task automatic test_stall(output logic [127:0] exp);
        int cyc;
        logic [127:0] st;
        st = {$urandom, $urandom, $urandom, $urandom};
        exp = model_run(st, 6);
        run_job(1, st, 6, 2, 10, -1, cyc);
        check_result("stall", 1, cyc, 47, exp);
    endtask

    task automatic test_done_hold(input logic [127:0] exp);
        for (int c = 0; c < 5; c++) begin
            start_v[1] = (c == 2);
            state_in_v[1] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge g_clk); #1;
            n_checks++;
            if (out_valid_v[1] !== 1'b1 || state_out_v[1] !== exp || rnd_idx_v[1] !== 6'd5) begin
                n_fail++;
                $display("FAIL done_hold: ov=%b state_out=%h rnd=%0d required 1 %h 5",
                         out_valid_v[1], state_out_v[1], rnd_idx_v[1], exp);
            end
        end
        start_v[1] = 1'b1;
        out_ready_v[1] = 1'b1;
        @(posedge g_clk); #1;
        start_v[1] = 1'b0;
        out_ready_v[1] = 1'b0;
        n_checks++;
        if (out_valid_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || rtk_ready_v[1] !== 1'b0 ||
            state_out_v[1] !== exp || rnd_idx_v[1] !== 6'd5) begin
            n_fail++;
            $display("FAIL done_release: ov=%b busy=%b rr=%b state_out=%h rnd=%0d required 0 0 0 %h 5",
                     out_valid_v[1], busy_v[1], rtk_ready_v[1], state_out_v[1], rnd_idx_v[1], exp);
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        logic [127:0] st;
        st = {$urandom, $urandom, $urandom, $urandom};
        run_job(1, st, 6, -1, 0, 3, cyc);
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(posedge g_clk); #1;
        run_job(1, st, 6, -1, 0, -1, cyc);
        check_result("after_abort", 1, cyc, 37, model_run(st, 6));
        finish_job(1);
    endtask

    task automatic test_full_rounds();
        int cyc;
        logic [127:0] st;
        for (int i = 0; i < 40; i++) tk_tab[i] = {$urandom, $urandom};
        st = {$urandom, $urandom, $urandom, $urandom};
        run_job(2, st, 40, -1, 0, -1, cyc);
        check_result("forty_rounds", 2, cyc, 241, model_run(st, 40));
        finish_job(2);
    endtask

    initial begin
        logic [127:0] stall_exp;
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_single_round();
        test_rc_sequence();
        test_stall(stall_exp);
        test_done_hold(stall_exp);
        test_reset_midrun();
        test_full_rounds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
